// File: rtl/wallace_tree_pkg.sv
// Shared constants for the wallace_tree multiplier: operand/product widths,
// per-layer row counts and latency (WALLACE_PIPE_EN adds a mid-tree register).
package wallace_pkg;

    localparam int OP_W   = 16;
    localparam int PROD_W = 32;

    localparam int ROWS_L0 = 16;
    localparam int ROWS_L1 = 11;
    localparam int ROWS_L2 = 8;
    localparam int ROWS_L3 = 6;
    localparam int ROWS_L4 = 4;
    localparam int ROWS_L5 = 3;
    localparam int ROWS_L6 = 2;

    localparam int NUM_LAYERS = 6;
    // Row level whose rows are registered when the pipeline stage is enabled.
    localparam int PIPE_LVL   = 3;

`ifdef WALLACE_PIPE_EN
    localparam int LATENCY = 2;
`else
    localparam int LATENCY = 1;
`endif

    function automatic int layer_rows(input int lvl);
        case (lvl)
            0:       return ROWS_L0;
            1:       return ROWS_L1;
            2:       return ROWS_L2;
            3:       return ROWS_L3;
            4:       return ROWS_L4;
            5:       return ROWS_L5;
            default: return ROWS_L6;
        endcase
    endfunction

endpackage

// File: rtl/wallace_tree_csa_3to2.sv
// Bit-vector 3:2 carry-save compressor: one full adder per bit position,
// carries pre-shifted into the next column weight.
module csa_3to2
    import wallace_pkg::*;
#(
    parameter int W = PROD_W
) (
    input  logic [W-1:0] x_i,
    input  logic [W-1:0] y_i,
    input  logic [W-1:0] z_i,
    output logic [W-1:0] sum_o,
    output logic [W-1:0] carry_o
);

    assign sum_o   = x_i ^ y_i ^ z_i;
    // Carry out of the top bit is dropped; it is always 0 for unsigned 16x16.
    assign carry_o = ((x_i & y_i) | (x_i & z_i) | (y_i & z_i)) << 1;

endmodule

// File: rtl/wallace_tree.sv
// Unsigned 16x16 Wallace-tree multiplier with registered 32-bit product.
// Define WALLACE_PIPE_EN to register the 6 rows after the third layer (latency 2).
module wallace_tree
    import wallace_pkg::*;
#(
    parameter int WIDTH = OP_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [2*WIDTH-1:0]   out
);

    localparam int PW = 2 * WIDTH;

    // No handshake: every rising edge samples a/b; out follows after LATENCY edges.
    logic [PW-1:0] lvl   [0:NUM_LAYERS][0:ROWS_L0-1];
    logic [PW-1:0] mid_d [0:ROWS_L3-1];
    logic [PW-1:0] out_d;
    logic [PW-1:0] out_q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_pp
        assign lvl[0][i] = PW'({{WIDTH{1'b0}}, a & {WIDTH{b[i]}}}) << i;
    end

    for (genvar l = 0; l < NUM_LAYERS; l++) begin : g_layer
        localparam int NI = layer_rows(l);
        localparam int NO = layer_rows(l + 1);
        localparam int G  = NI / 3;

        logic [PW-1:0] res [0:ROWS_L0-1];

        for (genvar g = 0; g < G; g++) begin : g_csa
            csa_3to2 #(.W(PW)) u_csa (
                .x_i     (lvl[l][3*g]),
                .y_i     (lvl[l][3*g+1]),
                .z_i     (lvl[l][3*g+2]),
                .sum_o   (res[2*g]),
                .carry_o (res[2*g+1])
            );
        end

        // Rows outside a complete group of three skip this layer untouched.
        for (genvar r = 3*G; r < NI; r++) begin : g_pass
            assign res[2*G + r - 3*G] = lvl[l][r];
        end

        for (genvar r = NO; r < ROWS_L0; r++) begin : g_zero
            assign res[r] = '0;
        end

        if (l + 1 == PIPE_LVL) begin : g_to_mid
            for (genvar r = 0; r < ROWS_L3; r++) begin : g_row
                assign mid_d[r] = res[r];
            end
        end else begin : g_to_next
            for (genvar r = 0; r < ROWS_L0; r++) begin : g_row
                assign lvl[l+1][r] = res[r];
            end
        end
    end

`ifdef WALLACE_PIPE_EN
    logic [PW-1:0] mid_q [0:ROWS_L3-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < ROWS_L3; r++) mid_q[r] <= '0;
        end else begin
            for (int r = 0; r < ROWS_L3; r++) mid_q[r] <= mid_d[r];
        end
    end
`endif

    for (genvar r = 0; r < ROWS_L0; r++) begin : g_mid
        if (r < ROWS_L3) begin : g_live
`ifdef WALLACE_PIPE_EN
            assign lvl[PIPE_LVL][r] = mid_q[r];
`else
            assign lvl[PIPE_LVL][r] = mid_d[r];
`endif
        end else begin : g_unused
            assign lvl[PIPE_LVL][r] = '0;
        end
    end

    assign out_d = lvl[NUM_LAYERS][0] + lvl[NUM_LAYERS][1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) out_q <= '0;
        else        out_q <= out_d;
    end

    assign out = out_q;

endmodule

// File: tb/tb_wallace_tree.sv
// Directed and random bench for wallace_tree; expected products are
// hand-computed constants or a*b, aligned to the configured latency.
module tb_wallace_tree;
    import wallace_pkg::*;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] p;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] out;

    logic [31:0] exp_q[$];
    logic [31:0] last_exp;
    int          n_checks;
    int          n_pass;
    vec_t        vecs[14];

    wallace_tree dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
        .out   (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: out=%0d (0x%08h) expected %0d (0x%08h)", name, act, act, exp, exp);
    endtask

    // Called at a falling edge: drive the pair, let one rising edge sample it,
    // then compare out against the product sampled LATENCY-1 edges earlier.
    task automatic step(input logic [15:0] va, input logic [15:0] vb,
                        input logic [31:0] vp, input string name, input bit glitch);
        a = va;
        b = vb;
        @(posedge clk);
        exp_q.push_back(vp);
        #1;
        if (exp_q.size() == LATENCY) begin
            last_exp = exp_q.pop_front();
            check(name, out, last_exp);
        end
        if (glitch) begin
            #2;
            a = 16'hFFFF;
            b = 16'hFFFF;
            #1;
            check("between_edges_stable", out, last_exp);
        end
        @(negedge clk);
    endtask

    task automatic prefill();
        exp_q.delete();
        repeat (LATENCY - 1) exp_q.push_back(32'd0);
    endtask

    task automatic flush(input string name);
        repeat (LATENCY - 1) step(16'd0, 16'd0, 32'd0, name, 1'b0);
    endtask

    initial begin
        logic [15:0] ra;
        logic [15:0] rb;
        n_checks = 0;
        n_pass   = 0;
        last_exp = '0;

        vecs[0]  = '{a: 16'd20,     b: 16'd30,     p: 32'd600};
        vecs[1]  = '{a: 16'd0,      b: 16'd65535,  p: 32'd0};
        vecs[2]  = '{a: 16'd65535,  b: 16'd0,      p: 32'd0};
        vecs[3]  = '{a: 16'd65535,  b: 16'd65535,  p: 32'hFFFE0001};
        vecs[4]  = '{a: 16'd1,      b: 16'd1,      p: 32'd1};
        vecs[5]  = '{a: 16'd2,      b: 16'd3,      p: 32'd6};
        vecs[6]  = '{a: 16'h8000,   b: 16'd2,      p: 32'd65536};
        vecs[7]  = '{a: 16'd12345,  b: 16'd6789,   p: 32'd83810205};
        vecs[8]  = '{a: 16'd255,    b: 16'd255,    p: 32'd65025};
        vecs[9]  = '{a: 16'h8000,   b: 16'h8000,   p: 32'h40000000};
        vecs[10] = '{a: 16'hAAAA,   b: 16'h5555,   p: 32'd954408050};
        vecs[11] = '{a: 16'd65535,  b: 16'd1,      p: 32'd65535};
        vecs[12] = '{a: 16'd1000,   b: 16'd1000,   p: 32'd1000000};
        vecs[13] = '{a: 16'd3,      b: 16'd5,      p: 32'd15};

        rst_n = 1'b1;
        a     = 16'd20;
        b     = 16'd30;
        #1 rst_n = 1'b0;
        #1 check("reset_async", out, 32'd0);
        repeat (2) @(posedge clk);
        #1 check("reset_hold_over_edges", out, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        prefill();

        for (int i = 0; i < 14; i++) begin
            step(vecs[i].a, vecs[i].b, vecs[i].p, $sformatf("vec%0d", i), (i == 0));
        end
        flush("vec_flush");

        // Leave one product in flight, then reset between edges.
        step(16'h1234, 16'h0010, 32'd74560, "inflight", 1'b0);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check("reset_mid_async", out, 32'd0);
        @(posedge clk);
        #1 check("reset_mid_hold", out, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        prefill();
        step(16'd7, 16'd9, 32'd63, "after_reset", 1'b0);
        flush("after_reset_flush");

        for (int i = 0; i < 1000; i++) begin
            ra = 16'($urandom_range(0, 65535));
            rb = 16'($urandom_range(0, 65535));
            step(ra, rb, 32'(ra) * 32'(rb), "random", 1'b0);
        end
        flush("random_flush");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
